// File: rtl/g_sbox_pipe_d2.sv
// Three-share masked LED G function, two-stage elastic pipeline.
// Optional RND_SHARED_EN: one RW-bit randomness bus shared by all nibbles.
module g_sbox_pipe_d2 #(
    parameter int NIBBLES = 16,
    parameter int RW      = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NIBBLES-1:0]  in_s0,
    input  logic [4*NIBBLES-1:0]  in_s1,
    input  logic [4*NIBBLES-1:0]  in_s2,
`ifdef RND_SHARED_EN
    input  logic [RW-1:0]         rnd,
`else
    input  logic [RW*NIBBLES-1:0] rnd,
`endif
    input  logic                  rnd_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NIBBLES-1:0]  out_s0,
    output logic [4*NIBBLES-1:0]  out_s1,
    output logic [4*NIBBLES-1:0]  out_s2
);

    logic v1;
    logic v2;
    logic accept;
    logic ld2;

    assign in_ready  = rst_n & (~v1 | ~v2 | out_ready);
    assign accept    = in_valid & rnd_valid & in_ready;
    assign ld2       = v1 & (~v2 | out_ready);
    assign out_valid = v2;

    // Masks added to the five spare component registers of one output
    // share; the three shares' masks cancel when recombined.
    function automatic logic [4:0] mask5(input int k, input logic [5:0] r);
        if (k == 0)
            return r[4:0];
        else if (k == 1)
            return {r[3:0], r[5]};
        else
            return {r[0] ^ r[1], r[1] ^ r[3], r[0] ^ r[3], r[5], r[4]};
    endfunction

    // Stage valid flags: stage 1 refills whenever it can pass data on,
    // stage 2 loads from stage 1 or empties on an output transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (in_ready)
                v1 <= accept;
            if (ld2)
                v2 <= 1'b1;
            else if (out_ready)
                v2 <= 1'b0;
        end
    end

    for (genvar n = 0; n < NIBBLES; n++) begin : g_nib
        logic [3:0]  sh [3];
        logic [17:0] rn;

        assign sh[0] = in_s0[4*n +: 4];
        assign sh[1] = in_s1[4*n +: 4];
        assign sh[2] = in_s2[4*n +: 4];

`ifdef RND_SHARED_EN
        assign rn = rnd[17:0];
`else
        assign rn = rnd[RW*n +: 18];
`endif

        for (genvar k = 0; k < 3; k++) begin : g_sh
            // Output share k only sees input shares k+1 and k+2.
            localparam int   I  = (k + 1) % 3;
            localparam int   J  = (k + 2) % 3;
            localparam logic C1 = (k == 0) ? 1'b1 : 1'b0;

            logic [3:0]      xi;
            logic [3:0]      xj;
            logic [2:0][8:0] fn;
            logic [2:0][8:0] f1;
            logic            gn;
            logic            g1;
            logic [3:0]      o;

            assign xi = sh[I];
            assign xj = sh[J];

            // y1 = a ^ b ^ c&d
            assign fn[0] = {mask5(k, rn[5:0]), xi[0] ^ xi[1],
                            xj[2] & xi[3], xi[2] & xj[3], xi[2] & xi[3]};
            // y2 = b ^ c ^ a&d
            assign fn[1] = {mask5(k, rn[11:6]), xi[1] ^ xi[2],
                            xj[0] & xi[3], xi[0] & xj[3], xi[0] & xi[3]};
            // y3 = c ^ d ^ a&b
            assign fn[2] = {mask5(k, rn[17:12]), xi[2] ^ xi[3],
                            xj[0] & xi[1], xi[0] & xj[1], xi[0] & xi[1]};
            // y0 = 1 ^ a ^ d, rotated share, constant on share 0
            assign gn = xi[0] ^ xi[3] ^ C1;

            // Stage 1 captures components on accept; stage 2 compresses.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    f1 <= '0;
                    g1 <= 1'b0;
                    o  <= '0;
                end else begin
                    if (accept) begin
                        f1 <= fn;
                        g1 <= gn;
                    end
                    if (ld2)
                        o <= {^f1[2], ^f1[1], ^f1[0], g1};
                end
            end

            if (k == 0) begin : g_o0
                assign out_s0[4*n +: 4] = o;
            end else if (k == 1) begin : g_o1
                assign out_s1[4*n +: 4] = o;
            end else begin : g_o2
                assign out_s2[4*n +: 4] = o;
            end
        end
    end

endmodule

// File: tb/tb_g_sbox_pipe_d2.sv
// Bench for g_sbox_pipe_d2: scoreboard of unmasked G results,
// directed vectors, backpressure, rnd_valid gaps and mid-flight reset.
module tb_g_sbox_pipe_d2;

    localparam int NIB = 16;
    localparam int RW  = 18;
    localparam int W   = 4 * NIB;
`ifdef RND_SHARED_EN
    localparam int RBW = RW;
`else
    localparam int RBW = RW * NIB;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_s0;
    logic [W-1:0]   in_s1;
    logic [W-1:0]   in_s2;
    logic [RBW-1:0] rnd;
    logic           rnd_valid;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_s0;
    logic [W-1:0]   out_s1;
    logic [W-1:0]   out_s2;

    g_sbox_pipe_d2 #(.NIBBLES(NIB), .RW(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s0     (in_s0),
        .in_s1     (in_s1),
        .in_s2     (in_s2),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s0    (out_s0),
        .out_s1    (out_s1),
        .out_s2    (out_s2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-evaluated G table, index x = {d,c,b,a}
    localparam logic [3:0] GT [16] = '{
        4'h1, 4'h2, 4'h7, 4'hC, 4'hD, 4'hE, 4'hB, 4'h0,
        4'h8, 4'hF, 4'hE, 4'h1, 4'h6, 4'h1, 4'h0, 4'hF
    };

    int           n_chk;
    int           n_err;
    int           n_acc;
    int           n_out;
    int           stalls;
    int           idx;
    int           a0;
    int           o0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] xv;
    logic [W-1:0] h0;
    logic [W-1:0] h1;
    logic [W-1:0] h2;
    logic [W-1:0] bp [3];

    function automatic logic [W-1:0] gexp(input logic [W-1:0] x);
        logic [W-1:0] r;
        logic [3:0]   v;
        r = '0;
        for (int n = 0; n < NIB; n++) begin
            v = x[4*n +: 4];
            r[4*n +: 4] = GT[v];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%h req=%h", nm, act, req);
        end
    endtask

    // Record the expected result of every accepted input
    always @(negedge clk) begin
        if (rst_n && in_valid && rnd_valid && in_ready) begin
            exp_q.push_back(gexp(in_s0 ^ in_s1 ^ in_s2));
            n_acc++;
        end
    end

    // Check every output transfer against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL spurious_out act=%h req=none",
                         out_s0 ^ out_s1 ^ out_s2);
            end else begin
                chk("out_xor", out_s0 ^ out_s1 ^ out_s2, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [W-1:0] x, input logic rv);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        in_s0 = a;
        in_s1 = b;
        in_s2 = x ^ a ^ b;
        for (int i = 0; i < RBW; i++)
            rnd[i] = 1'($urandom_range(0, 1));
        in_valid  = 1'b1;
        rnd_valid = rv;
    endtask

    task automatic send(input logic [W-1:0] x);
        int t;
        t = 0;
        drive(x, 1'b1);
        @(negedge clk);
        while (!in_ready && t < 40) begin
            t++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout act=%0d req=accept", t);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 30) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", W'(exp_q.size()), '0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; n_acc = 0; n_out = 0; stalls = 0;
        rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
        out_ready = 1'b1;
        in_s0 = '0; in_s1 = '0; in_s2 = '0; rnd = '0;

        // Reset held for two edges
        @(negedge clk);
        chk("rst_in_ready_low", W'(in_ready), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_s0", out_s0, '0);
        chk("rst_out_s1", out_s1, '0);
        chk("rst_out_s2", out_s2, '0);
        chk("rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        // Directed values and latency
        send('0);
        @(negedge clk);
        chk("lat_c1", W'(out_valid), '0);
        @(negedge clk);
        chk("lat_c2", W'(out_valid), W'(1));
        @(posedge clk);
        #1;
        send({NIB{4'hF}});
        send({NIB{4'h1}});
        drain();

        // Every value in every nibble, back to back
        stalls = 0;
        for (int v = 0; v < 16; v++) begin
            for (int n = 0; n < NIB; n++)
                xv[4*n +: 4] = 4'((v + n) % 16);
            send(xv);
        end
        chk("no_stall", W'(stalls), '0);
        drain();

        // Backpressure: 3 items offered, 5 stalled cycles
        bp[0] = 64'h0123456789ABCDEF;
        bp[1] = 64'hFEDCBA9876543210;
        bp[2] = 64'h5A5A3C3C96960F0F;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 3)
                drive(bp[idx], 1'b1);
            @(negedge clk);
            if (in_valid && in_ready)
                idx++;
            if (c == 2) begin
                chk("bp_out_valid", W'(out_valid), W'(1));
                h0 = out_s0; h1 = out_s1; h2 = out_s2;
            end
            if (c > 2) begin
                chk("bp_hold_s0", out_s0, h0);
                chk("bp_hold_s1", out_s1, h1);
                chk("bp_hold_s2", out_s2, h2);
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepts", W'(idx), W'(2));
        chk("bp_in_ready", W'(in_ready), '0);
        out_ready = 1'b1;
        send(bp[2]);
        drain();

        // rnd_valid gaps: accepts only on fresh randomness
        a0 = n_acc;
        o0 = n_out;
        for (int c = 0; c < 5; c++) begin
            drive({NIB{4'(c + 3)}}, (c % 2) == 0);
            @(negedge clk);
            chk("rv_in_ready", W'(in_ready), W'(1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        chk("rv_accepts", W'(n_acc - a0), W'(3));
        drain();
        chk("rv_outputs", W'(n_out - o0), W'(3));

        // Reset with two items in flight
        out_ready = 1'b0;
        send({NIB{4'hA}});
        send({NIB{4'h3}});
        o0 = n_out;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_in_ready", W'(in_ready), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst2_out_valid", W'(out_valid), '0);
        chk("rst2_out_s0", out_s0, '0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst2_no_emit", W'(n_out - o0), '0);
        chk("rst2_idle", W'(out_valid), '0);

        // Normal operation after reset
        send(64'hC0FFEE0123456789);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
